ppt_cmd_scheduler: RTL and testbench
====================================

# ppt_cmd_scheduler

Command scheduler for the presentation-controller top level. Debounces four raw push-button inputs (next, previous, blank, start) and queues one pending request per button. A round-robin arbiter shares a single UART transmitter between the four requesters, sending one ASCII command byte per accepted press. It sits between the `ui_in` button pins and a `uo_out` serial pin in the top-level wrapper.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a level change; must be ≥1.
- `CLKS_PER_BIT`, 8: clock cycles per UART bit; must be ≥2.

- `clk`  in  1  single system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high.
- `ena`  in  1  enable; low blocks new press capture and new grants.
- `btn`  in  4  raw buttons, active-high, asynchronous to `clk`: [0] next, [1] prev, [2] blank, [3] start.
- `tx`  out  1  UART 8N1 serial output; idle high.
- `busy`  out  1  high while a frame is in flight (FSM not IDLE).
- `pending`  out  4  per-button request latched, not yet granted.
- `cmd_code`  out  8  code of the most recently granted command.

## Operation
- Reset values: `tx`=1, `busy`=0, `pending`=0, `cmd_code`=0x00. Sync/debounced state=0, counters=0, FSM=IDLE, RR pointer=3.
- Per button: 2-FF synchronizer, then debouncer. Counter increments each edge where synced value ≠ debounced value; clears on any edge where they match. The debounced value flips on the `DEBOUNCE_CYCLES`-th consecutive differing edge. Counter width is clog2(`DEBOUNCE_CYCLES`+1).
- Press event = debounced 0→1 while `ena`=1. It sets `pending[i]` on the same edge. Releases never generate events. Presses while `ena`=0 are discarded; debouncers keep running.
- Pending is one-deep per button. Further presses while the bit is already set are dropped.
- Codes: btn0 0x4E 'N', btn1 0x50 'P', btn2 0x42 'B', btn3 0x53 'S'.
- Arbiter: evaluated only in IDLE with `ena`=1 and `pending`≠0.
  - Search starts at index (ptr+1) mod 4 and increments; the first set bit wins.
  - On the grant edge: clear that pending bit, set ptr to the winner, load `cmd_code` and the shift register, go to START.
- Simultaneous press event and grant of the same button on one edge: the set wins and the bit stays pending (new request).
- FSM: IDLE → START (`tx`=0) → DATA (8 bits, LSB first) → STOP (`tx`=1) → IDLE.
  - Each of START, each data bit, and STOP lasts exactly `CLKS_PER_BIT` cycles.
  - Bit counter is 3 bits; baud counter width is clog2(`CLKS_PER_BIT`).
- `ena` deasserted mid-frame: the current frame completes normally; pending bits are retained and no new grant is made until `ena`=1.
- `rst` mid-frame: `tx` goes to 1 immediately without waiting for a clock; all state clears; the partial frame is abandoned.
- `tx` is driven from a register (glitch-free).

## Timing
- Debounce latency: count the first edge that samples a new raw level as edge 1. The debounced flip and `pending` set occur at edge `DEBOUNCE_CYCLES`+2.
- Grant occurs at the first edge where IDLE, `ena`=1 and `pending`≠0. `tx` falls and `busy` rises on that same edge.
- Frame length: 10×`CLKS_PER_BIT` cycles from the grant edge to the return to IDLE.
- Back-to-back: each IDLE visit lasts at least 1 cycle. The idle-high gap between consecutive frames is therefore at least 1 cycle; the STOP bit is `CLKS_PER_BIT` cycles.
- Throughput: at most one command per 10×`CLKS_PER_BIT`+1 cycles.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `CLKS_PER_BIT`=4.
- Reset/idle: assert `rst` for 3 cycles, then release; hold `btn`=0 for 100 cycles -> `tx`=1, `busy`=0, `pending`=0, `cmd_code`=0x00 throughout.
- Single press: raise `btn[0]` and hold -> `pending`=0001 at edge 6, then grant on the next edge. `tx` carries 0, then 0x4E LSB-first (0,1,1,1,0,0,1,0), then 1. Each bit lasts 4 cycles; `busy` is high for 40 cycles; `cmd_code`=0x4E.
- Bounce rejection: toggle `btn[1]` high for 3 cycles and low for 1 cycle, repeated 5×, then leave it low -> no pending bit set and `tx` stays 1.
- Round-robin: with the FSM busy, press `btn[3]`, `btn[1]` and `btn[0]` -> `pending`=1011. Frames follow in the order 0x4E, 0x50, 0x53, each separated by 1 idle cycle.
- Same-edge set/grant and overflow:
  - Re-press `btn[2]` so its event coincides with its own grant edge -> 0x42 is sent twice.
  - Press `btn[0]` three times during one frame -> 0x4E is sent once only.
- `ena` and reset mid-frame:
  - Drop `ena` during DATA -> the frame completes, no next grant is made, and pending is retained.
  - Assert `rst` mid-frame -> `tx`=1 asynchronously and all outputs return to their reset values.

Source files
------------

// File: rtl/ppt_cmd_scheduler_if.sv
// Button and UART bundle of the presentation command scheduler.
// The master drives enable and raw buttons; the slave (scheduler) drives the rest.
interface ppt_cmd_scheduler_if;
    logic       ena;
    logic [3:0] btn;
    logic       tx;
    logic       busy;
    logic [3:0] pending;
    logic [7:0] cmd_code;

    modport master (
        output ena, btn,
        input  tx, busy, pending, cmd_code
    );

    modport slave (
        input  ena, btn,
        output tx, busy, pending, cmd_code
    );
endinterface

// File: rtl/ppt_cmd_scheduler.sv
// Debounced four-button command scheduler with round-robin UART 8N1 output.
// One pending request per button; one ASCII byte per granted press.
module ppt_cmd_scheduler #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CLKS_PER_BIT    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    ppt_cmd_scheduler_if.slave        bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [3:0]         sync1_q, sync2_q;
    logic [3:0]         db_q, db_d;
    logic [3:0][DW-1:0] cnt_q, cnt_d;
    logic [3:0]         pend_q, pend_d;
    logic [3:0]         press, grant;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         win, idx;
    logic               found;
    state_t             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [7:0]         code_q, code_d;
    logic               tx_q, tx_d;

    function automatic logic [7:0] code_of(input logic [1:0] b);
        logic [7:0] c;
        unique case (b)
            2'd0: c = 8'h4E;
            2'd1: c = 8'h50;
            2'd2: c = 8'h42;
            2'd3: c = 8'h53;
        endcase
        return c;
    endfunction

    // Debouncers: flip after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        press = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    cnt_d[i] = '0;
                    db_d[i]  = sync2_q[i];
                    press[i] = sync2_q[i] & bus.ena;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Frame FSM next state, grant and pending update.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        code_d  = code_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        grant   = '0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.ena && found) begin
                    grant[win] = 1'b1;
                    ptr_d      = win;
                    code_d     = code_of(win);
                    shreg_d    = code_of(win);
                    tx_d       = 1'b0;
                    baud_d     = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new press on the grant edge re-arms the same button.
        pend_d = (pend_q & ~grant) | press;
    end

    // State registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            ptr_q   <= 2'd3;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            code_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            code_q  <= code_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.pending  = pend_q;
    assign bus.cmd_code = code_q;
endmodule

// File: tb/tb_ppt_cmd_scheduler.sv
// Bench for ppt_cmd_scheduler: timeline reference model, UART decoder,
// per-button vector table and hand-written multi-cycle sequences.
module tb_ppt_cmd_scheduler;
    localparam int D   = 4;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ppt_cmd_scheduler_if bus ();

    ppt_cmd_scheduler #(
        .DEBOUNCE_CYCLES(D),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] CODES [4] = '{8'h4E, 8'h50, 8'h42, 8'h53};

    // Reference model: edge count, debounce run lengths, frame timeline.
    int         cyc = 0;
    logic [3:0] m_s1, m_s2, m_db, m_pend;
    int         m_run [4];
    int         m_last;
    bit         m_active;
    int         m_fstart;
    logic [7:0] m_code;

    always @(posedge clk) begin
        logic [3:0] ev;
        bit idle_before;
        int w;
        cyc++;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_last = 3; m_active = 0; m_fstart = 0; m_code = 8'h00;
        end else begin
            ev = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_db[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_db[i] && bus.ena) ev[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            idle_before = !m_active;
            if (m_active && (cyc - m_fstart) == 10 * CPB) m_active = 0;
            if (idle_before && bus.ena && m_pend != 0) begin
                w = m_last;
                for (int k = 1; k <= 4; k++) begin
                    if (m_pend[(m_last + k) % 4]) begin
                        w = (m_last + k) % 4;
                        break;
                    end
                end
                m_pend[w] = 1'b0;
                m_last = w;
                m_code = CODES[w];
                m_fstart = cyc;
                m_active = 1;
            end
            m_pend = m_pend | ev;
            m_s2 = m_s1;
            m_s1 = bus.btn;
        end
    end

    // Continuous comparison of all outputs against the model.
    always @(negedge clk) begin
        logic exp_tx;
        int slot;
        if (!rst && chk_en) begin
            exp_tx = 1'b1;
            if (m_active) begin
                slot = (cyc - m_fstart) / CPB;
                if (slot == 0) exp_tx = 1'b0;
                else if (slot <= 8) exp_tx = m_code[slot-1];
            end
            checks++;
            if ({bus.tx, bus.busy, bus.pending, bus.cmd_code} !==
                {exp_tx, m_active, m_pend, m_code}) begin
                errors++;
                $display("FAIL model cyc=%0d got tx=%b busy=%b pend=%b code=%h exp tx=%b busy=%b pend=%b code=%h",
                         cyc, bus.tx, bus.busy, bus.pending, bus.cmd_code,
                         exp_tx, m_active, m_pend, m_code);
            end
        end
    end

    // UART receiver: samples mid-bit, checks the stop bit.
    logic [7:0] rx_q [$];
    bit         mon_on = 1'b0;
    int         mt = 0;
    logic [7:0] mb;

    always @(negedge clk) begin
        if (rst) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (bus.tx == 1'b0) begin
                mon_on = 1'b1;
                mt = 0;
            end
        end else begin
            mt++;
            if (mt >= CPB + CPB/2 && mt < 9*CPB && (mt - CPB/2) % CPB == 0)
                mb[(mt - CPB/2) / CPB - 1] = bus.tx;
            if (mt == 9*CPB + CPB/2) begin
                checks++;
                if (bus.tx !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_bit got=%b exp=1", bus.tx);
                end
                rx_q.push_back(mb);
                mon_on = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        bus.btn = 4'h0;
        bus.ena = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        rx_q.delete();
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.pending != 4'h0) && n < 1000) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n >= 1000), 32'd0);
        repeat (2) tick();
    endtask

    task automatic wait_grant(output int f);
        int n = 0;
        while (!m_active && n < 50) begin
            tick();
            n++;
        end
        chk("grant_timeout", 32'(n >= 50), 32'd0);
        f = m_fstart;
    endtask

    task automatic check_rx(input string nm, input int n,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++)
            chk({nm, "_byte"}, 32'(rx_q[i]), 32'(e[i]));
    endtask

    typedef struct {
        logic [3:0] btn;
        logic [3:0] exp_pend;
        logic [7:0] exp_code;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, f0, n;
        int hold [4];
        tbl[0] = '{4'b0001, 4'b0001, 8'h4E};
        tbl[1] = '{4'b0010, 4'b0010, 8'h50};
        tbl[2] = '{4'b0100, 4'b0100, 8'h42};
        tbl[3] = '{4'b1000, 4'b1000, 8'h53};
        bus.btn = 4'h0;
        bus.ena = 1'b1;

        // Reset and idle.
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pend", 32'(bus.pending), 32'd0);
        chk("rst_code", 32'(bus.cmd_code), 32'd0);
        repeat (100) tick();
        chk("idle_tx", 32'(bus.tx), 32'd1);
        chk("idle_pend", 32'(bus.pending), 32'd0);

        // Single press per button.
        for (int v = 0; v < 4; v++) begin
            rx_q.delete();
            base = cyc;
            bus.btn = tbl[v].btn;
            wait_until(base + 5);
            chk("press_early", 32'(bus.pending), 32'd0);
            wait_until(base + 6);
            chk("press_pend", 32'(bus.pending), 32'(tbl[v].exp_pend));
            chk("press_nobusy", 32'(bus.busy), 32'd0);
            wait_until(base + 7);
            chk("grant_busy", 32'(bus.busy), 32'd1);
            chk("grant_tx", 32'(bus.tx), 32'd0);
            chk("grant_code", 32'(bus.cmd_code), 32'(tbl[v].exp_code));
            chk("grant_pend", 32'(bus.pending), 32'd0);
            n = 0;
            while (bus.busy && n < 100) begin
                n++;
                tick();
            end
            chk("busy_len", 32'(n), 32'(10 * CPB));
            bus.btn = 4'h0;
            repeat (10) tick();
            check_rx("press_rx", 1, tbl[v].exp_code, 8'h0, 8'h0, 8'h0);
        end

        // Bounce rejection.
        do_reset();
        repeat (5) begin
            bus.btn[1] = 1'b1;
            repeat (3) tick();
            bus.btn[1] = 1'b0;
            tick();
        end
        repeat (20) tick();
        chk("bounce_pend", 32'(bus.pending), 32'd0);
        chk("bounce_tx", 32'(bus.tx), 32'd1);
        chk("bounce_rx", 32'(rx_q.size()), 32'd0);

        // Round-robin after a start frame.
        do_reset();
        bus.btn = 4'b1000;
        wait_grant(f0);
        wait_until(f0 + 1);
        bus.btn = 4'b0000;
        wait_until(f0 + 10);
        bus.btn = 4'b1011;
        wait_until(f0 + 20);
        chk("rr_pend", 32'(bus.pending), 32'b1011);
        wait_until(f0 + 25);
        bus.btn = 4'b0000;
        wait_idle();
        check_rx("rr_rx", 4, 8'h53, 8'h4E, 8'h50, 8'h53);

        // Press lands on its own grant edge.
        do_reset();
        bus.btn = 4'b0001;
        wait_grant(f0);
        wait_until(f0 + 2);
        bus.btn = 4'b0100;
        wait_until(f0 + 10);
        bus.btn = 4'b0000;
        wait_until(f0 + 35);
        bus.btn = 4'b0100;
        wait_until(f0 + 41);
        chk("same_busy", 32'(bus.busy), 32'd1);
        chk("same_code", 32'(bus.cmd_code), 32'h42);
        chk("same_pend", 32'(bus.pending), 32'b0100);
        wait_until(f0 + 45);
        bus.btn = 4'b0000;
        wait_idle();
        check_rx("same_rx", 3, 8'h4E, 8'h42, 8'h42, 8'h0);

        // Repeated presses collapse into one request.
        do_reset();
        bus.btn = 4'b1000;
        wait_grant(f0);
        wait_until(f0 + 1);
        bus.btn = 4'b0000;
        for (int p = 0; p < 3; p++) begin
            wait_until(f0 + 2 + 14 * p);
            bus.btn[0] = 1'b1;
            wait_until(f0 + 9 + 14 * p);
            bus.btn[0] = 1'b0;
        end
        wait_until(f0 + 39);
        chk("ovf_pend", 32'(bus.pending), 32'b0001);
        wait_idle();
        check_rx("ovf_rx", 2, 8'h53, 8'h4E, 8'h0, 8'h0);

        // Enable dropped during DATA.
        do_reset();
        bus.btn = 4'b0001;
        wait_grant(f0);
        wait_until(f0 + 1);
        bus.btn = 4'b0000;
        wait_until(f0 + 2);
        bus.btn = 4'b0010;
        wait_until(f0 + 10);
        bus.btn = 4'b0000;
        wait_until(f0 + 12);
        bus.ena = 1'b0;
        wait_until(f0 + 60);
        chk("ena_busy", 32'(bus.busy), 32'd0);
        chk("ena_pend", 32'(bus.pending), 32'b0010);
        chk("ena_tx", 32'(bus.tx), 32'd1);
        chk("ena_code", 32'(bus.cmd_code), 32'h4E);
        bus.ena = 1'b1;
        wait_idle();
        check_rx("ena_rx", 2, 8'h4E, 8'h50, 8'h0, 8'h0);

        // Asynchronous reset mid-frame.
        do_reset();
        bus.btn = 4'b0001;
        wait_grant(f0);
        wait_until(f0 + 5);
        chk("mid_tx_low", 32'(bus.tx), 32'd0);
        bus.btn = 4'b0000;
        rst = 1'b1;
        #1;
        chk("async_tx", 32'(bus.tx), 32'd1);
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_pend", 32'(bus.pending), 32'd0);
        chk("async_code", 32'(bus.cmd_code), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("async_rx", 32'(rx_q.size()), 32'd0);

        // Randomized buttons and enable against the model.
        do_reset();
        for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 12);
        repeat (3000) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    bus.btn[i] = ~bus.btn[i];
                    hold[i] = $urandom_range(1, 12);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 63) == 0) bus.ena = ~bus.ena;
        end
        bus.btn = 4'h0;
        bus.ena = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
